// File: rtl/complex_div_arbiter.sv
// complex_div_arbiter: shares one complex_div unit between NUM_REQ requesters.
// Issue side is round-robin; the ID of each accepted requester goes into a tag
// FIFO, and in-order results are steered back to the FIFO head's requester.
// Both paths are purely combinational through the arbiter (zero added cycles).
//
// Handshake semantics (all channels): a transfer happens on a rising clk_i edge
// where valid and ready are both 1. valid must not depend on ready; a source
// holds valid and its payload stable until the transfer. ready may depend on
// valid (here req_ready_o depends on the grant, div_out_ready_o on the head tag).
module complex_div_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 64,
    parameter int MAX_OUTST = 8
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            flush_i,
    input  logic [NUM_REQ*4*DATA_W-1:0]     req_operands_i,
    input  logic [NUM_REQ-1:0]              req_valid_i,
    output logic [NUM_REQ-1:0]              req_ready_o,
    output logic [2*DATA_W-1:0]             rsp_result_o,
    output logic [NUM_REQ-1:0]              rsp_valid_o,
    input  logic [NUM_REQ-1:0]              rsp_ready_i,
    output logic [4*DATA_W-1:0]             div_operands_o,
    output logic                            div_in_valid_o,
    input  logic                            div_in_ready_i,
    input  logic [2*DATA_W-1:0]             div_result_i,
    input  logic                            div_out_valid_i,
    output logic                            div_out_ready_o,
    output logic                            div_flush_o,
    output logic [$clog2(MAX_OUTST):0]      outstanding_o,
    output logic                            err_o,
    output logic                            busy_o
);

    localparam int TW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CW  = $clog2(MAX_OUTST) + 1;
    localparam int OPW = 4 * DATA_W;

    // Round-robin pointer, tag FIFO and in-flight counter
    logic [TW-1:0] rr_ptr_q, rr_ptr_d;
    logic [TW-1:0] tag_mem_q [MAX_OUTST];
    logic [TW-1:0] tag_mem_d [MAX_OUTST];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;

    // Combinational control
    logic               gnt_found;
    logic [TW-1:0]      gnt_idx;
    logic [NUM_REQ-1:0] grant;
    logic               credit;
    logic               push;
    logic               pop;
    logic               fifo_empty;
    logic               orphan;
    logic [TW-1:0]      head_tag;

    // Requester index base+off, wrapping at NUM_REQ-1 -> 0
    function automatic logic [TW-1:0] wrap_idx(input logic [TW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return sum[TW-1:0];
    endfunction

    // First valid requester searching upward from rr_ptr
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = rr_ptr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_found && req_valid_i[wrap_idx(rr_ptr_q, i)]) begin
                gnt_found = 1'b1;
                gnt_idx   = wrap_idx(rr_ptr_q, i);
            end
        end
    end

    // One-hot grant vector and operand mux of the granted requester
    always_comb begin
        grant          = '0;
        div_operands_o = '0;
        if (gnt_found) grant[gnt_idx] = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == TW'(i)) div_operands_o = req_operands_i[i*OPW +: OPW];
        end
    end

    // Issue/response handshakes; control outputs are held low during reset
    always_comb begin
        fifo_empty      = (count_q == '0);
        head_tag        = tag_mem_q[rd_ptr_q];
        credit          = (count_q < CW'(MAX_OUTST)) && !flush_i;
        div_in_valid_o  = !rst_i && gnt_found && credit;
        req_ready_o     = (!rst_i && credit && div_in_ready_i) ? grant : '0;
        push            = div_in_valid_o && div_in_ready_i;
        rsp_valid_o     = '0;
        if (!rst_i && !flush_i && !fifo_empty && div_out_valid_i) rsp_valid_o[head_tag] = 1'b1;
        // Empty FIFO or flush: results are drained and dropped
        if (rst_i)                       div_out_ready_o = 1'b0;
        else if (fifo_empty || flush_i)  div_out_ready_o = 1'b1;
        else                             div_out_ready_o = rsp_ready_i[head_tag];
        pop             = div_out_valid_i && div_out_ready_o && !fifo_empty && !flush_i;
        orphan          = !rst_i && div_out_valid_i && fifo_empty && !flush_i;
    end

    // Next-state for pointers, tag FIFO, counter and sticky error
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        tag_mem_d = tag_mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        err_d     = err_q | orphan;
        if (push) rr_ptr_d = wrap_idx(gnt_idx, 1);
        if (flush_i) begin
            // Drop every tag; rr_ptr and err are kept
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push) begin
                tag_mem_d[wr_ptr_q] = gnt_idx;
                wr_ptr_d            = wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < MAX_OUTST; i++) tag_mem_q[i] <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_q     <= err_d;
            tag_mem_q <= tag_mem_d;
        end
    end

    assign rsp_result_o  = div_result_i;
    assign div_flush_o   = flush_i;
    assign outstanding_o = count_q;
    assign err_o         = err_q;
    assign busy_o        = (count_q != '0) || (|req_valid_i);

endmodule

// File: tb/tb_complex_div_arbiter.sv
// Testbench for complex_div_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// queue-based model of the arbiter (tag queue, rr index, sticky error).
module tb_complex_div_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 64;
  localparam int MAX_OUTST = 8;
  localparam int OPW       = 4 * DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                        flush;
  logic [NUM_REQ*OPW-1:0]      req_operands;
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_ready;
  logic [2*DATA_W-1:0]         rsp_result;
  logic [NUM_REQ-1:0]          rsp_valid;
  logic [NUM_REQ-1:0]          rsp_ready;
  logic [OPW-1:0]              div_operands;
  logic                        div_in_valid;
  logic                        div_in_ready;
  logic [2*DATA_W-1:0]         div_result;
  logic                        div_out_valid;
  logic                        div_out_ready;
  logic                        div_flush;
  logic [$clog2(MAX_OUTST):0]  outstanding;
  logic                        err;
  logic                        busy;

  complex_div_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .MAX_OUTST(MAX_OUTST)
  ) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .req_operands_i(req_operands), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .rsp_result_o(rsp_result), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .div_operands_o(div_operands), .div_in_valid_o(div_in_valid), .div_in_ready_i(div_in_ready),
    .div_result_i(div_result), .div_out_valid_i(div_out_valid), .div_out_ready_o(div_out_ready),
    .div_flush_o(div_flush), .outstanding_o(outstanding), .err_o(err), .busy_o(busy)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model state: queue of issued requester IDs in issue order
  logic [1:0] exp_q[$];
  int         rr_m  = 0;
  logic       err_m = 1'b0;

  // Compare process: checks every output against the model mid-cycle, then
  // advances the model with the handshakes that will happen at the next edge.
  always @(negedge clk) begin : compare
    int                 g;
    int                 cnt;
    logic               credit_m, empty_m, e_inv, e_oready;
    logic [NUM_REQ-1:0] e_ready, e_rvalid;
    logic [1:0]         head;
    if (rst) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_div_in_valid", div_in_valid, 0);
      chk("rst_div_out_ready", div_out_ready, 0);
      chk("rst_outstanding", outstanding, 0);
      chk("rst_err", err, 0);
      exp_q.delete();
      rr_m  = 0;
      err_m = 1'b0;
    end else begin
      cnt      = exp_q.size();
      credit_m = (cnt < MAX_OUTST) && !flush;
      g = -1;
      for (int k = 0; k < NUM_REQ; k++)
        if (g < 0 && req_valid[(rr_m + k) % NUM_REQ]) g = (rr_m + k) % NUM_REQ;
      empty_m  = (cnt == 0);
      head     = empty_m ? 2'd0 : exp_q[0];
      e_inv    = (g >= 0) && credit_m;
      e_ready  = (e_inv && div_in_ready) ? (4'b0001 << g) : 4'b0000;
      e_rvalid = (!flush && !empty_m && div_out_valid) ? (4'b0001 << head) : 4'b0000;
      e_oready = (flush || empty_m) ? 1'b1 : rsp_ready[head];
      chk("div_in_valid", div_in_valid, e_inv);
      chk("req_ready", req_ready, e_ready);
      chk("rsp_valid", rsp_valid, e_rvalid);
      chk("div_out_ready", div_out_ready, e_oready);
      chk("rsp_result", rsp_result, div_result);
      chk("outstanding", outstanding, cnt);
      chk("err", err, err_m);
      chk("busy", busy, (cnt != 0) || (|req_valid));
      chk("div_flush", div_flush, flush);
      if (g >= 0) chk("div_operands", div_operands, req_operands[g*OPW +: OPW]);
      // advance model
      if (flush) begin
        exp_q.delete();
      end else begin
        if (div_out_valid && empty_m) err_m = 1'b1;
        if (div_out_valid && e_oready && !empty_m) void'(exp_q.pop_front());
        if (e_inv && div_in_ready) begin
          exp_q.push_back(g[1:0]);
          rr_m = (g + 1) % NUM_REQ;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic half();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    nxt(); nxt();
    rst = 1'b0;
  endtask

  task automatic set_ops(input int idx, input real a1, input real b1, input real a2, input real b2);
    req_operands[idx*OPW +: OPW] = {$realtobits(b2), $realtobits(a2), $realtobits(b1), $realtobits(a1)};
  endtask

  task automatic randomize_inputs();
    for (int w = 0; w < NUM_REQ*OPW/32; w++) req_operands[w*32 +: 32] = $urandom();
    for (int w = 0; w < 2*DATA_W/32; w++) div_result[w*32 +: 32] = $urandom();
    req_valid     = 4'($urandom_range(0, 15));
    div_in_ready  = ($urandom_range(0, 3) != 0);
    div_out_valid = ($urandom_range(0, 2) == 0);
    rsp_ready     = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
    flush         = ($urandom_range(0, 63) == 0);
    rst           = ($urandom_range(0, 499) == 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [OPW-1:0] ops_exp;
    rst = 1'b1; flush = 1'b0; req_operands = '0; req_valid = '0;
    rsp_ready = '0; div_in_ready = 1'b0; div_result = '0; div_out_valid = 1'b0;
    repeat (3) nxt();
    rst = 1'b0;

    // Single requester: 4/2
    set_ops(0, 4.0, 0.0, 2.0, 0.0);
    ops_exp = {$realtobits(0.0), $realtobits(2.0), $realtobits(0.0), $realtobits(4.0)};
    req_valid = 4'b0001; div_in_ready = 1'b1;
    half();
    chk("single_ready", req_ready, 4'b0001);
    chk("single_in_valid", div_in_valid, 1'b1);
    chk("single_ops", div_operands, ops_exp);
    nxt();
    req_valid = 4'b0000; div_out_valid = 1'b1; rsp_ready = 4'hF;
    div_result = {$realtobits(0.0), $realtobits(2.0)};
    half();
    chk("single_outst1", outstanding, 1);
    chk("single_rsp_valid", rsp_valid, 4'b0001);
    chk("single_result", rsp_result, {64'h0, 64'h4000_0000_0000_0000});
    nxt();
    div_out_valid = 1'b0;
    half();
    chk("single_outst0", outstanding, 0);
    nxt();

    // Round-robin with all requesters valid
    do_reset();
    req_valid = 4'hF; div_in_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      half(); chk("rr_grant", req_ready, 4'b0001 << (i % 4)); nxt();
    end
    req_valid = 4'h0; div_out_valid = 1'b1; rsp_ready = 4'hF;
    for (int i = 0; i < 5; i++) begin
      half(); chk("rr_rsp", rsp_valid, 4'b0001 << (i % 4)); nxt();
    end
    div_out_valid = 1'b0;

    // Credit backpressure at MAX_OUTST
    do_reset();
    req_valid = 4'hF; div_in_ready = 1'b1;
    repeat (MAX_OUTST) nxt();
    half();
    chk("bp_ready_full", req_ready, 4'b0000);
    chk("bp_outst_full", outstanding, MAX_OUTST);
    nxt();
    div_out_valid = 1'b1;
    half();
    chk("bp_pop_rsp", rsp_valid, 4'b0001);
    nxt();
    div_out_valid = 1'b0;
    half();
    chk("bp_outst_after", outstanding, MAX_OUTST - 1);
    chk("bp_reopen", req_ready, 4'b0001);
    nxt();

    // Flush with 5 in flight
    do_reset();
    req_valid = 4'hF;
    repeat (5) nxt();
    flush = 1'b1; div_out_valid = 1'b1;
    half();
    chk("flush_outst5", outstanding, 5);
    chk("flush_rsp", rsp_valid, 4'b0000);
    chk("flush_ready", req_ready, 4'b0000);
    chk("flush_out", div_flush, 1'b1);
    nxt();
    flush = 1'b0; div_out_valid = 1'b0;
    half();
    chk("flush_outst0", outstanding, 0);
    chk("flush_err", err, 1'b0);
    chk("flush_rr_held", req_ready, 4'b0010);
    nxt();
    req_valid = 4'h0;

    // Orphan result
    do_reset();
    div_out_valid = 1'b1;
    half();
    chk("orphan_oready", div_out_ready, 1'b1);
    chk("orphan_rsp", rsp_valid, 4'b0000);
    nxt();
    div_out_valid = 1'b0;
    half();
    chk("orphan_err", err, 1'b1);
    repeat (3) nxt();
    half();
    chk("orphan_sticky", err, 1'b1);
    do_reset();
    half();
    chk("orphan_cleared", err, 1'b0);
    nxt();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      randomize_inputs();
      nxt();
    end
    rst = 1'b0; flush = 1'b0;
    nxt();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
